// File: rtl/sram_pkg.sv
// Shared constants for the SRAM responder: FSM state encodings, bus width,
// default geometry/timing parameters and a small saturating-counter helper.
package sram_pkg;

  localparam int SRAM_DW         = 8;
  localparam int SRAM_AW_DEF     = 17;
  localparam int SRAM_RD_LAT_DEF = 2;
  localparam int SRAM_WR_MIN_DEF = 2;

  localparam logic [3:0] ST_IDLE     = 4'd0;
  localparam logic [3:0] ST_WR_PULSE = 4'd1;
  localparam logic [3:0] ST_RD_WAIT  = 4'd2;
  localparam logic [3:0] ST_RD_DRIVE = 4'd3;

  // Idle level of the active-low {ce, oe, we} control group.
  localparam logic [2:0] SYNC_IDLE = 3'b111;

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/sram_resp_sync.sv
// Two-flop synchroniser for the active-low {ce, oe, we} pins; resets to the
// idle (deasserted) level so the responder never sees a phantom access.
module sram_resp_sync
  import sram_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] async_in,
  output logic [2:0] sync_out
);

  logic [2:0] meta_q, meta_d;
  logic [2:0] sync_q, sync_d;

  always_comb begin
    meta_d = async_in;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_q <= SYNC_IDLE;
      sync_q <= SYNC_IDLE;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign sync_out = sync_q;

endmodule

// File: rtl/sram_responder.sv
// Async-SRAM device model answering the ce/oe/we/data pin interface.
// Optional timing checker enabled by defining SRAM_RESP_TIMING_CHK_EN.
module sram_responder
  import sram_pkg::*;
#(
  parameter int AW     = SRAM_AW_DEF,
  parameter int RD_LAT = SRAM_RD_LAT_DEF,
  parameter int WR_MIN = SRAM_WR_MIN_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ce,
  input  logic                oe,
  input  logic                we,
  input  logic [AW-1:0]       addr,
  inout  wire  [SRAM_DW-1:0]  data,
  output logic                busy,
  output logic [15:0]         acc_cnt,
  output logic                tim_err
);

  localparam logic [3:0] RD_LAST  = 4'(RD_LAT - 1);
  localparam logic [4:0] WR_MIN_W = 5'(WR_MIN);

  logic [2:0] ctrl_s;
  logic       ce_s, oe_s, we_s;

  sram_resp_sync u_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in ({ce, oe, we}),
    .sync_out (ctrl_s)
  );

  assign {ce_s, oe_s, we_s} = ctrl_s;

  logic [AW-1:0]      addr_p1_q, addr_p1_d, addr_s_q, addr_s_d;
  logic [SRAM_DW-1:0] data_p1_q, data_p1_d, data_s_q, data_s_d;
  logic [3:0]         state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [AW-1:0]      addr_l_q, addr_l_d;
  logic [SRAM_DW-1:0] wr_data_q, wr_data_d;
  logic [15:0]        acc_q, acc_d;
  logic [SRAM_DW-1:0] rd_q;
  logic               mem_we, rd_load, wr_ok;

  logic [SRAM_DW-1:0] mem [2**AW];

  // Address and data travel through two stages so they line up with the synced controls.
  always_comb begin
    addr_p1_d = addr;
    addr_s_d  = addr_p1_q;
    data_p1_d = data;
    data_s_d  = data_p1_q;
  end

  assign wr_ok = ({1'b0, cnt_q} + 5'd1) >= WR_MIN_W;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_l_d  = addr_l_q;
    wr_data_d = wr_data_q;
    acc_d     = acc_q;
    mem_we    = 1'b0;
    rd_load   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!ce_s && !we_s) begin
          state_d   = ST_WR_PULSE;
          addr_l_d  = addr_s_q;
          wr_data_d = data_s_q;
          cnt_d     = 4'd0;
        end else if (!ce_s && !oe_s) begin
          addr_l_d = addr_s_q;
          // The IDLE decode cycle already counts toward the read latency.
          if (RD_LAT == 1) begin
            state_d = ST_RD_DRIVE;
            rd_load = 1'b1;
            acc_d   = acc_q + 16'd1;
          end else begin
            state_d = ST_RD_WAIT;
            cnt_d   = 4'd1;
          end
        end
      end
      ST_WR_PULSE: begin
        if (we_s || ce_s) begin
          state_d = ST_IDLE;
          if (wr_ok) begin
            mem_we = 1'b1;
            acc_d  = acc_q + 16'd1;
          end
        end else begin
          cnt_d     = sat_inc4(cnt_q);
          wr_data_d = data_s_q;
        end
      end
      ST_RD_WAIT: begin
        if (oe_s || ce_s || !we_s) begin
          state_d = ST_IDLE;
        end else if (cnt_q == RD_LAST) begin
          state_d  = ST_RD_DRIVE;
          rd_load  = 1'b1;
          addr_l_d = addr_s_q;
          acc_d    = acc_q + 16'd1;
        end else begin
          cnt_d = sat_inc4(cnt_q);
        end
      end
      ST_RD_DRIVE: begin
        if (oe_s || ce_s || !we_s) begin
          state_d = ST_IDLE;
        end else if (addr_s_q != addr_l_q) begin
          state_d = ST_RD_WAIT;
          cnt_d   = 4'd0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_p1_q <= '0;
      addr_s_q  <= '0;
      data_p1_q <= '0;
      data_s_q  <= '0;
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      addr_l_q  <= '0;
      wr_data_q <= '0;
      acc_q     <= 16'd0;
    end else begin
      addr_p1_q <= addr_p1_d;
      addr_s_q  <= addr_s_d;
      data_p1_q <= data_p1_d;
      data_s_q  <= data_s_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_l_q  <= addr_l_d;
      wr_data_q <= wr_data_d;
      acc_q     <= acc_d;
    end
  end

  // Single-port array: writes and reads occur in different states, never together.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[addr_l_q] <= wr_data_q;
    end
    if (rd_load) begin
      rd_q <= mem[addr_s_q];
    end
  end

  assign data    = (state_q == ST_RD_DRIVE) ? rd_q : {SRAM_DW{1'bz}};
  assign busy    = (state_q != ST_IDLE);
  assign acc_cnt = acc_q;

`ifdef SRAM_RESP_TIMING_CHK_EN
  logic short_wr;
  logic oe_prev_q, oe_prev_d;
  logic tim_err_q, tim_err_d;

  assign short_wr = (state_q == ST_WR_PULSE) && (we_s || ce_s) && !wr_ok;

  always_comb begin
    oe_prev_d = oe_s;
    tim_err_d = tim_err_q | short_wr | (oe_prev_q & ~oe_s & ~we_s);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      oe_prev_q <= 1'b1;
      tim_err_q <= 1'b0;
    end else begin
      oe_prev_q <= oe_prev_d;
      tim_err_q <= tim_err_d;
    end
  end

  assign tim_err = tim_err_q;
`else
  assign tim_err = 1'b0;
`endif

endmodule

// File: tb/tb_sram_responder.sv
// Self-checking bench for sram_responder: directed pin scenarios plus a randomized
// write/read mix compared against an address-indexed byte model.
module tb_sram_responder;
  import sram_pkg::*;

  localparam int AW     = SRAM_AW_DEF;
  localparam int RD_LAT = SRAM_RD_LAT_DEF;
  localparam int WR_MIN = SRAM_WR_MIN_DEF;

`ifdef SRAM_RESP_TIMING_CHK_EN
  localparam bit TIM_CHK = 1'b1;
`else
  localparam bit TIM_CHK = 1'b0;
`endif

  localparam logic [8:0] BUS_IDLE = 9'h100;

  logic          clk = 1'b0;
  logic          rst;
  logic          ce = 1'b1;
  logic          oe = 1'b1;
  logic          we = 1'b1;
  logic [AW-1:0] addr = '0;
  wire  [7:0]    data;
  logic          busy;
  logic [15:0]   acc_cnt;
  logic          tim_err;

  logic [7:0] tb_data = 8'h00;
  logic       tb_drv  = 1'b0;

  assign data = tb_drv ? tb_data : 8'hzz;

  sram_responder #(
    .AW     (AW),
    .RD_LAT (RD_LAT),
    .WR_MIN (WR_MIN)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .ce      (ce),
    .oe      (oe),
    .we      (we),
    .addr    (addr),
    .data    (data),
    .busy    (busy),
    .acc_cnt (acc_cnt),
    .tim_err (tim_err)
  );

  always #5 clk = ~clk;

  int          checks   = 0;
  int          failures = 0;
  logic [7:0]  model [int];
  int          written [$];
  logic [15:0] acc_exp = 16'd0;
  logic        tim_exp = 1'b0;

  // Stored bytes are always nonzero, so a released bus (z, or 0 in a 2-state sim) is unambiguous.
  function automatic logic [8:0] busView();
    if ($isunknown(data) || data == 8'h00) return BUS_IDLE;
    return {1'b0, data};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic c, input logic o, input logic w,
                               input logic [AW-1:0] a, input logic drv, input logic [7:0] d);
    ce      = c;
    oe      = o;
    we      = w;
    addr    = a;
    tb_drv  = drv;
    tb_data = d;
  endtask

  task automatic settle();
    applyStimulus(1'b1, 1'b1, 1'b1, addr, 1'b0, 8'h00);
    repeat (5) tick();
    checkOutput("idle_busy", 32'(busy), 32'd0);
    checkOutput("idle_acc", 32'(acc_cnt), 32'(acc_exp));
    checkOutput("idle_tim_err", 32'(tim_err), 32'(tim_exp));
    checkOutput("idle_bus", 32'(busView()), 32'(BUS_IDLE));
  endtask

  task automatic noteCommit(input logic [AW-1:0] a, input logic [7:0] d);
    if (!model.exists(int'(a))) written.push_back(int'(a));
    model[int'(a)] = d;
    acc_exp++;
  endtask

  task automatic doWrite(input logic [AW-1:0] a, input logic [7:0] d, input int n);
    applyStimulus(1'b0, 1'b1, 1'b0, a, 1'b1, d);
    repeat (n) tick();
    if (n >= WR_MIN) noteCommit(a, d);
    else if (TIM_CHK) tim_exp = 1'b1;
    settle();
  endtask

  task automatic doRead(input logic [AW-1:0] a, input int hold);
    logic [7:0] exp_byte;
    exp_byte = model[int'(a)];
    applyStimulus(1'b0, 1'b0, 1'b1, a, 1'b0, 8'h00);
    for (int k = 1; k <= RD_LAT + 2 + hold; k++) begin
      tick();
      if (k < RD_LAT + 2) checkOutput("rd_hiz", 32'(busView()), 32'(BUS_IDLE));
      else checkOutput("rd_data", 32'(busView()), {23'd0, 1'b0, exp_byte});
      if (k == RD_LAT + 2) begin
        checkOutput("rd_busy", 32'(busy), 32'd1);
        checkOutput("rd_acc", 32'(acc_cnt), 32'(acc_exp) + 32'd1);
      end
    end
    acc_exp++;
    settle();
  endtask

  initial begin
    logic [AW-1:0] a;
    logic [7:0]    d;

    rst = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b1, '0, 1'b0, 8'h00);
    repeat (3) tick();
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_acc", 32'(acc_cnt), 32'd0);
    checkOutput("rst_tim_err", 32'(tim_err), 32'd0);
    checkOutput("rst_bus", 32'(busView()), 32'(BUS_IDLE));
    rst = 1'b1;
    repeat (2) tick();

    // Long write then read back.
    doWrite(17'h00010, 8'hA5, 8);
    doRead(17'h00010, 2);

    // Write pulse boundary: one sample short is dropped, exactly WR_MIN commits.
    doWrite(17'h00010, 8'h77, WR_MIN - 1);
    doRead(17'h00010, 0);
    doWrite(17'h00020, 8'h5A, WR_MIN);
    doRead(17'h00020, 1);

    // Address change with oe held low starts a fresh read.
    doWrite(17'h00001, 8'h11, 3);
    doWrite(17'h00002, 8'h22, 3);
    applyStimulus(1'b0, 1'b0, 1'b1, 17'h00001, 1'b0, 8'h00);
    repeat (RD_LAT + 2) tick();
    checkOutput("addr_chg_first", 32'(busView()), 32'h11);
    acc_exp++;
    applyStimulus(1'b0, 1'b0, 1'b1, 17'h00002, 1'b0, 8'h00);
    for (int k = 1; k <= RD_LAT + 3; k++) begin
      tick();
      if (k <= 2) checkOutput("addr_chg_old", 32'(busView()), 32'h11);
      else if (k <= RD_LAT + 2) checkOutput("addr_chg_hiz", 32'(busView()), 32'(BUS_IDLE));
      else checkOutput("addr_chg_new", 32'(busView()), 32'h22);
    end
    acc_exp++;
    settle();

    // we and oe low together: the write wins.
    applyStimulus(1'b0, 1'b0, 1'b0, 17'h00030, 1'b1, 8'h3C);
    repeat (4) tick();
    checkOutput("both_low_busy", 32'(busy), 32'd1);
    noteCommit(17'h00030, 8'h3C);
    if (TIM_CHK) tim_exp = 1'b1;
    settle();
    doRead(17'h00030, 0);

    // Asynchronous reset while the bus is being driven.
    doWrite(17'h00040, 8'hC3, 4);
    applyStimulus(1'b0, 1'b0, 1'b1, 17'h00040, 1'b0, 8'h00);
    repeat (RD_LAT + 2) tick();
    checkOutput("pre_rst_drive", 32'(busView()), 32'hC3);
    #2 rst = 1'b0;
    #1;
    checkOutput("async_rst_bus", 32'(busView()), 32'(BUS_IDLE));
    checkOutput("async_rst_busy", 32'(busy), 32'd0);
    checkOutput("async_rst_acc", 32'(acc_cnt), 32'd0);
    acc_exp = 16'd0;
    tim_exp = 1'b0;
    tick();
    applyStimulus(1'b1, 1'b1, 1'b1, '0, 1'b0, 8'h00);
    tick();
    rst = 1'b1;
    repeat (2) tick();
    doRead(17'h00040, 0);
    doRead(17'h00010, 0);

    // Randomized mix of writes (including short pulses) and reads of written bytes.
    for (int i = 0; i < 40; i++) begin
      if (written.size() == 0 || $urandom_range(0, 2) == 0) begin
        a = AW'($urandom());
        d = 8'($urandom_range(1, 255));
        doWrite(a, d, int'($urandom_range(1, 6)));
      end else begin
        a = AW'(written[$urandom_range(0, written.size() - 1)]);
        doRead(a, int'($urandom_range(0, 3)));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
